// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch/decode/exec/mem/wb sequencing for the 8-bit datapath.
// Optional performance counters (ciclos, instrucoes) enabled by `define CONTADOR_DESEMPENHO_EN.
module unidade_controle (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_dado,
  input  logic        instr_pronto,
  input  logic        mem_pronto,
  input  logic        zero,
  output logic        instr_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  Controle_ALUop,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        mem_re,
  output logic        mem_we,
  output logic [2:0]  reg_rd,
  output logic [2:0]  reg_rs,
  output logic [2:0]  reg_rt,
  output logic [7:0]  imm_ext,
  output logic        halted,
  output logic        erro,
  output logic [2:0]  estado
`ifdef CONTADOR_DESEMPENHO_EN
  ,
  output logic [15:0] ciclos,
  output logic [15:0] instrucoes
`endif
);

  typedef enum logic [2:0] {
    INICIO = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERRO   = 3'd7
  } estado_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_J    = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  estado_t    estado_q;
  logic [3:0] opcode;

  // State register and instruction latch; fields only change on FETCH acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= INICIO;
      opcode   <= 4'h0;
      reg_rd   <= 3'd0;
      reg_rs   <= 3'd0;
      reg_rt   <= 3'd0;
      imm_ext  <= 8'h00;
    end else begin
      case (estado_q)
        INICIO: estado_q <= FETCH;
        FETCH: begin
          if (instr_pronto) begin
            opcode   <= instr_dado[15:12];
            reg_rd   <= instr_dado[11:9];
            reg_rs   <= instr_dado[8:6];
            reg_rt   <= instr_dado[5:3];
            imm_ext  <= {{2{instr_dado[5]}}, instr_dado[5:0]};
            estado_q <= DECODE;
          end
        end
        DECODE: begin
          if (opcode inside {4'hC, 4'hD, 4'hE}) estado_q <= ERRO;
          else if (opcode == OP_HALT)           estado_q <= HALT;
          else                                  estado_q <= EXEC;
        end
        EXEC: begin
          if (opcode == OP_LW || opcode == OP_SW)      estado_q <= MEM;
          else if (opcode == OP_BEQ || opcode == OP_J) estado_q <= FETCH;
          else                                         estado_q <= WB;
        end
        MEM: begin
          if (mem_pronto) estado_q <= (opcode == OP_LW) ? WB : FETCH;
        end
        WB:      estado_q <= FETCH;
        default: estado_q <= estado_q;
      endcase
    end
  end

  // Strobes decode from state and latched opcode; only FETCH acceptance and BEQ look at inputs
  always_comb begin
    instr_req      = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    pc_src         = 2'b00;
    Controle_ALUop = 2'b00;
    alu_src_b      = 1'b0;
    reg_we         = 1'b0;
    mem_to_reg     = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    halted         = 1'b0;
    erro           = 1'b0;
    case (estado_q)
      FETCH: begin
        instr_req = 1'b1;
        ir_we     = instr_pronto;
        pc_we     = instr_pronto;
      end
      EXEC: begin
        case (opcode)
          OP_SUB, OP_SLT, OP_BEQ: Controle_ALUop = 2'b01;
          OP_AND, OP_ANDI:        Controle_ALUop = 2'b10;
          OP_OR, OP_ORI:          Controle_ALUop = 2'b11;
          default:                Controle_ALUop = 2'b00;
        endcase
        alu_src_b = (opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW});
        if (opcode == OP_BEQ) begin
          pc_src = 2'b01;
          pc_we  = zero;
        end else if (opcode == OP_J) begin
          pc_src = 2'b10;
          pc_we  = 1'b1;
        end
      end
      MEM: begin
        mem_re = (opcode == OP_LW);
        mem_we = (opcode == OP_SW);
      end
      WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (opcode == OP_LW);
      end
      HALT:    halted = 1'b1;
      ERRO:    erro   = 1'b1;
      default: ;
    endcase
  end

  assign estado = estado_q;

`ifdef CONTADOR_DESEMPENHO_EN
  logic fim_instr;

  // An instruction completes on any transition back into FETCH
  assign fim_instr = (estado_q == WB) ||
                     (estado_q == EXEC && (opcode == OP_BEQ || opcode == OP_J)) ||
                     (estado_q == MEM && mem_pronto && opcode == OP_SW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ciclos     <= 16'h0000;
      instrucoes <= 16'h0000;
    end else begin
      if (!(estado_q inside {INICIO, HALT, ERRO}) && ciclos != 16'hFFFF)
        ciclos <= ciclos + 16'd1;
      if (fim_instr && instrucoes != 16'hFFFF)
        instrucoes <= instrucoes + 16'd1;
    end
  end
`endif

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit for the 8-bit datapath, directly upstream of the ALU. It fetches a 16-bit instruction through a ready handshake, latches and decodes it, and sequences FETCH/DECODE/EXEC/MEM/WB. In each state it drives `Controle_ALUop`, operand/PC/writeback selects and register/memory strobes. It consumes the ALU `zero` flag for BEQ.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `instr_dado`  in  16  instruction word from instruction memory
- `instr_pronto`  in  1  instruction memory ready; sampled only in FETCH
- `mem_pronto`  in  1  data memory ready; sampled only in MEM
- `zero`  in  1  ALU equality flag
- `instr_req`  out  1  instruction fetch request
- `ir_we`  out  1  instruction latched this cycle
- `pc_we`  out  1  PC update strobe
- `pc_src`  out  2  00 PC+1, 01 branch target, 10 jump target
- `Controle_ALUop`  out  2  ALU operation select
- `alu_src_b`  out  1  0 register rt, 1 `imm_ext`
- `reg_we`  out  1  register file write strobe
- `mem_to_reg`  out  1  writeback source: 0 ALU, 1 memory
- `mem_re` / `mem_we`  out  1 each  data memory read/write request
- `reg_rd`, `reg_rs`, `reg_rt`  out  3 each  latched fields instr[11:9], [8:6], [5:3]
- `imm_ext`  out  8  latched instr[5:0], sign-extended
- `halted`, `erro`  out  1 each  terminal status flags
- `estado`  out  3  current state encoding

## Operation
- Opcode is instr[15:12]:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
  - 5 ADDI, 6 ANDI, 7 ORI
  - 8 BEQ, 9 LW, A SW, B J
  - F HALT
  - C–E illegal
- ALUop mapping:
  - 00: ADD, ADDI, LW, SW
  - 01: SUB, SLT, BEQ
  - 10: AND, ANDI
  - 11: OR, ORI
- States, with `estado` encoding:
  - INICIO=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERRO=7.
- INICIO: all strobes 0 for one cycle, then FETCH.
- FETCH: `instr_req`=1. On `instr_pronto`=1, the same cycle asserts `ir_we`=1, `pc_we`=1, `pc_src`=00; the instruction is latched and the next state is DECODE. Otherwise FETCH is held.
- DECODE: one cycle. Opcodes C–E go to ERRO, F goes to HALT, all others go to EXEC.
- EXEC: drives `Controle_ALUop` per opcode. `alu_src_b`=1 for ADDI/ANDI/ORI/LW/SW, 0 otherwise. Next state per opcode:
  - R/I-type: WB.
  - LW/SW: MEM.
  - BEQ: `pc_src`=01, `pc_we`=`zero`, then FETCH.
  - J: `pc_src`=10, `pc_we`=1, then FETCH.
- MEM: LW holds `mem_re`=1 and SW holds `mem_we`=1 until `mem_pronto`. Then LW goes to WB and SW goes to FETCH.
- WB: `reg_we`=1 for exactly one cycle; `mem_to_reg`=1 only for LW. Then FETCH.
- HALT: `halted`=1. ERRO: `erro`=1. Both states are terminal until reset.
- Strobes are Moore outputs decoded from state and the latched opcode. Any strobe not listed for a state is 0.

## Timing
- Reset asserted: state INICIO. All outputs 0, including latched fields, `imm_ext` and `estado`.
- Reset is asynchronous, so asserting it mid-instruction aborts immediately and no strobe survives the edge.
- Cycles per instruction, counted from the first FETCH cycle with zero memory wait:
  - R/I-type: 4
  - BEQ, J: 3
  - SW: 4
  - LW: 5
- Each wait cycle on `instr_pronto` or `mem_pronto` adds exactly one cycle.
- `instr_pronto` outside FETCH and `mem_pronto` outside MEM are ignored.
- `ir_we` and `pc_we` coincide with the FETCH acceptance cycle. Latched fields become valid from the DECODE cycle and stay stable until the next acceptance.
- `zero` is sampled in the EXEC cycle only.

## Configuration
- `CONTADOR_DESEMPENHO_EN` defined: adds two 16-bit outputs.
  - `ciclos` counts every cycle outside INICIO/HALT/ERRO.
  - `instrucoes` increments on each instruction completion: the transition to FETCH from EXEC, MEM or WB.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Macro undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, `instr_pronto`=1 constantly, ADD (16'h0298) → `estado` 0,1,2,3,5,1. `Controle_ALUop`=00 in EXEC; `reg_we`=1 only in WB; `reg_rd`=1, `reg_rs`=2, `reg_rt`=3.
- ADDI with imm 6'b111110 → `imm_ext`=8'hFE, `alu_src_b`=1 in EXEC.
- BEQ:
  - `zero`=1 in EXEC → `pc_we`=1, `pc_src`=01.
  - `zero`=0 → `pc_we`=0.
  - Either way, next state is FETCH.
- LW with `mem_pronto` low for 2 cycles → MEM lasts 3 cycles with `mem_re`=1; WB has `mem_to_reg`=1 and `reg_we`=1; 7 cycles total.
- Opcode 4'hC → ERRO with `erro`=1, held for 10 cycles. Opcode 4'hF → `halted`=1. In both cases `instr_req` stays 0 until reset.
- Reset asserted in MEM with `mem_we`=1 → all outputs 0 asynchronously, before the next clock edge. With `CONTADOR_DESEMPENHO_EN`, `instrucoes`=0 after reset and 3 after three completed ADDs.
